byte_mem_arbiter: RTL and testbench

- Shares one single-port, byte-wide, synchronous data memory between two 32-bit word requesters.
- Port 0 is the CPU load/store path; port 1 is the memory loader/debug path.
- Each accepted word access is serialised into four big-endian byte accesses: base+0 holds bits [31:24], base+3 holds bits [7:0].
- Arbitration between simultaneous requests is round-robin.

---
 rtl/byte_mem_arbiter_pkg.sv | 28 ++
 rtl/byte_mem_arbiter_rr_arbiter2.sv | 38 +++
 rtl/byte_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_byte_mem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_mem_arbiter_pkg.sv
// Shared types and constants for the two-port word-to-byte memory arbiter.
// Byte 0 of a word is its most significant byte (big-endian layout in memory).
package byte_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_TAIL  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int unsigned BYTES_PER_WORD = 4;

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/byte_mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; on a tie the port opposite the last grant wins.
// last_grant advances only when the accept strobe is asserted.
module rr_arbiter2
    import byte_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       winner
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        winner = PORT_CPU;
        if (req[0] && req[1]) begin
            winner = ~last_grant_q;
        end else if (req[1]) begin
            winner = PORT_LDR;
        end

        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_LDR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/byte_mem_arbiter.sv
// Shares one byte-wide synchronous memory between a CPU port and a loader port,
// serialising each 32-bit word access into four big-endian byte accesses.
module byte_mem_arbiter
    import byte_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_ack,
    output logic [31:0]       ldr_rdata,

    output logic              busy,
    output logic              gnt_id,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       ldr_rdata_q, ldr_rdata_d;

    logic              accept;
    logic              winner;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({ldr_req, cpu_req}),
        .accept (accept),
        .winner (winner)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        accept      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req || ldr_req) begin
                    accept  = 1'b1;
                    owner_d = winner;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                    if (winner == PORT_LDR) begin
                        we_d    = ldr_we;
                        addr_d  = ldr_addr;
                        wdata_d = ldr_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end

            ST_ISSUE: begin
                // Read data lags the enable by one cycle, so issue k returns byte k-1.
                if (!we_q) begin
                    case (cnt_q)
                        2'd1:    asm_d[23:16] = mem_rdata;
                        2'd2:    asm_d[15:8]  = mem_rdata;
                        2'd3:    asm_d[7:0]   = mem_rdata;
                        default: ;
                    endcase
                end
                if (cnt_q == LAST_BYTE) begin
                    cnt_d   = '0;
                    state_d = ST_TAIL;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            ST_TAIL: begin
                if (!we_q) begin
                    if (owner_q == PORT_LDR) begin
                        ldr_rdata_d = {asm_q, mem_rdata};
                    end else begin
                        cpu_rdata_d = {asm_q, mem_rdata};
                    end
                end
                state_d = ST_ACK;
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_ISSUE) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q + ADDR_W'(cnt_q);
            mem_wdata = word_byte(wdata_q, cnt_q);
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign gnt_id    = busy ? owner_q : PORT_CPU;
    assign cpu_ack   = (state_q == ST_ACK) && (owner_q == PORT_CPU);
    assign ldr_ack   = (state_q == ST_ACK) && (owner_q == PORT_LDR);
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= PORT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Self-checking bench for byte_mem_arbiter: a byte memory model behind the DUT and a
// word-level reference memory updated with big-endian stores.
module tb_byte_mem_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;
    logic              ldr_req = 1'b0, ldr_we = 1'b0;
    logic [ADDR_W-1:0] ldr_addr = '0;
    logic [31:0]       ldr_wdata = '0;
    logic              ldr_ack;
    logic [31:0]       ldr_rdata;
    logic              busy, gnt_id;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = '0;

    logic [7:0] mem     [DEPTH];
    logic [7:0] ref_mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    byte_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_ack   (ldr_ack),
        .ldr_rdata (ldr_rdata),
        .busy      (busy),
        .gnt_id    (gnt_id),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    function automatic void ref_write(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        logic [ADDR_W-1:0] idx;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = a + ADDR_W'(i);
            ref_mem[idx] = w[31 - 8*i -: 8];
        end
    endfunction

    function automatic logic [31:0] ref_read(input logic [ADDR_W-1:0] a);
        logic [31:0]       w;
        logic [ADDR_W-1:0] idx;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = a + ADDR_W'(i);
            w[31 - 8*i -: 8] = ref_mem[idx];
        end
        return w;
    endfunction

    // Drives one word access on a port and measures it; callers do the comparisons.
    task automatic run_word(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wdata, input bit perturb,
                            output logic [31:0] rd, output int lat, output int stray,
                            output bit ack_long, output bit we_bad);
        lat = -1; stray = 0; ack_long = 1'b0; we_bad = 1'b0;
        if (port) begin
            ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; ldr_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (perturb && c == 1) begin
                if (port) begin ldr_addr = addr + 5'd3; ldr_wdata = ~wdata; end
                else      begin cpu_addr = addr + 5'd3; cpu_wdata = ~wdata; end
            end
            if (mem_en && (mem_we !== we)) we_bad = 1'b1;
            if (port ? cpu_ack : ldr_ack) stray++;
            if (port ? ldr_ack : cpu_ack) begin
                lat = c;
                break;
            end
        end
        rd = port ? ldr_rdata : cpu_rdata;
        @(posedge clk); #1;
        if (port ? ldr_ack : cpu_ack) ack_long = 1'b1;
        if (port) ldr_req = 1'b0;
        else      cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({cpu_ack, ldr_ack, busy, gnt_id, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got ack=%b%b busy=%b gnt=%b en=%b we=%b addr=%h wd=%h exp all 0",
                     cpu_ack, ldr_ack, busy, gnt_id, mem_en, mem_we, mem_addr, mem_wdata);
        end
        n_tests++;
        if ({cpu_rdata, ldr_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata got cpu=%h ldr=%h exp 0", cpu_rdata, ldr_rdata);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        logic [31:0] w, rd;
        int lat, stray;
        bit al, wb;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            run_word(1'b1, 1'b1, ADDR_W'(i * 4), w, 1'b0, rd, lat, stray, al, wb);
            ref_write(ADDR_W'(i * 4), w);
            n_tests++;
            if (lat != 6) begin
                n_fail++;
                $display("FAIL fill_latency word %0d got %0d exp 6", i, lat);
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            n_tests++;
            if (mem[i] !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL fill_mem[%0d] got %h exp %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_cpu_write();
        logic [31:0] rd;
        int lat, stray;
        bit al, wb;
        run_word(1'b0, 1'b1, 5'h04, 32'hDEADBEEF, 1'b0, rd, lat, stray, al, wb);
        ref_write(5'h04, 32'hDEADBEEF);
        n_tests++;
        if (lat != 6) begin n_fail++; $display("FAIL cpu_write_latency got %0d exp 6", lat); end
        n_tests++;
        if (stray != 0) begin n_fail++; $display("FAIL cpu_write_ldr_ack got %0d exp 0", stray); end
        n_tests++;
        if (al) begin n_fail++; $display("FAIL cpu_write_ack_pulse got 2+ cycles exp 1"); end
        n_tests++;
        if ({mem[4], mem[5], mem[6], mem[7]} !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL cpu_write_bytes got %h %h %h %h exp DE AD BE EF", mem[4], mem[5], mem[6], mem[7]);
        end
    endtask

    task automatic test_ldr_read();
        logic [31:0] rd;
        int lat, stray;
        bit al, wb;
        run_word(1'b1, 1'b0, 5'h04, 32'h0, 1'b0, rd, lat, stray, al, wb);
        n_tests++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ldr_read_data got %h exp deadbeef", rd); end
        n_tests++;
        if (wb) begin n_fail++; $display("FAIL ldr_read_mem_we got 1 exp 0"); end
        n_tests++;
        if (lat != 6 || stray != 0 || al) begin
            n_fail++;
            $display("FAIL ldr_read_handshake got lat=%0d stray=%0d long=%0d exp 6 0 0", lat, stray, al);
        end
        run_word(1'b0, 1'b1, 5'h0C, 32'h5A5A0F0F, 1'b0, rd, lat, stray, al, wb);
        ref_write(5'h0C, 32'h5A5A0F0F);
        n_tests++;
        if (ldr_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ldr_rdata_hold got %h exp deadbeef", ldr_rdata); end
        n_tests++;
        if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL cpu_rdata_after_write got %h exp 0", cpu_rdata); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        int lat, stray;
        bit al, wb;
        run_word(1'b0, 1'b1, 5'h1E, 32'h11223344, 1'b0, rd, lat, stray, al, wb);
        ref_write(5'h1E, 32'h11223344);
        n_tests++;
        if ({mem[30], mem[31], mem[0], mem[1]} !== 32'h11223344) begin
            n_fail++;
            $display("FAIL wrap_bytes got %h %h %h %h exp 11 22 33 44", mem[30], mem[31], mem[0], mem[1]);
        end
        run_word(1'b1, 1'b0, 5'h1E, 32'h0, 1'b0, rd, lat, stray, al, wb);
        n_tests++;
        if (rd !== 32'h11223344) begin n_fail++; $display("FAIL wrap_read got %h exp 11223344", rd); end
    endtask

    task automatic test_back_to_back();
        int order [4];
        int t_ack [4];
        int n_ack = 0;
        int both = 0;
        logic [31:0] cw, lw;
        @(negedge clk) rst_n = 1'b0;
        cw = $urandom; lw = $urandom;
        cpu_we = 1'b1; cpu_addr = 5'h10; cpu_wdata = cw; cpu_req = 1'b1;
        ldr_we = 1'b1; ldr_addr = 5'h14; ldr_wdata = lw; ldr_req = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        for (int cyc = 1; cyc <= 60 && n_ack < 4; cyc++) begin
            @(posedge clk); #1;
            if (cpu_ack && ldr_ack) both++;
            if (cpu_ack) begin
                order[n_ack] = 0; t_ack[n_ack] = cyc; n_ack++;
                ref_write(5'h10, cw);
                cw = $urandom; cpu_wdata = cw;
            end else if (ldr_ack) begin
                order[n_ack] = 1; t_ack[n_ack] = cyc; n_ack++;
                ref_write(5'h14, lw);
                lw = $urandom; ldr_wdata = lw;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; ldr_req = 1'b0;
        n_tests++;
        if (n_ack != 4) begin n_fail++; $display("FAIL rr_ack_count got %0d exp 4", n_ack); end
        n_tests++;
        if (both != 0) begin n_fail++; $display("FAIL rr_dual_ack got %0d exp 0", both); end
        for (int i = 0; i < n_ack; i++) begin
            n_tests++;
            if (order[i] != (i % 2)) begin
                n_fail++;
                $display("FAIL rr_order[%0d] got port %0d exp port %0d", i, order[i], i % 2);
            end
            n_tests++;
            if (t_ack[i] != 6 + 7 * i) begin
                n_fail++;
                $display("FAIL rr_ack_time[%0d] got cycle %0d exp %0d", i, t_ack[i], 6 + 7 * i);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle_after got busy=%b exp 0", busy); end
        for (int i = 16; i < 24; i++) begin
            n_tests++;
            if (mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL rr_mem[%0d] got %h exp %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat, stray, acks;
        bit al, wb;
        run_word(1'b0, 1'b1, 5'h08, 32'h01020304, 1'b0, rd, lat, stray, al, wb);
        ref_write(5'h08, 32'h01020304);
        run_word(1'b0, 1'b0, 5'h08, 32'h0, 1'b0, rd, lat, stray, al, wb);
        n_tests++;
        if (rd !== 32'h01020304) begin n_fail++; $display("FAIL pre_reset_read got %h exp 01020304", rd); end
        cpu_we = 1'b1; cpu_addr = 5'h08; cpu_wdata = 32'hA5A5A5A5; cpu_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (mem_en !== 1'b1 || mem_addr !== 5'h0A) begin
            n_fail++;
            $display("FAIL mid_issue2 got en=%b addr=%h exp 1 0a", mem_en, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_abort got en=%b busy=%b exp 0 0", mem_en, busy);
        end
        cpu_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (cpu_ack || ldr_ack) acks++;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (cpu_ack || ldr_ack) acks++;
        end
        n_tests++;
        if (acks != 0) begin n_fail++; $display("FAIL abort_no_ack got %0d acks exp 0", acks); end
        ref_mem[8] = 8'hA5; ref_mem[9] = 8'hA5;
        n_tests++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'hA5A50304) begin
            n_fail++;
            $display("FAIL abort_bytes got %h %h %h %h exp a5 a5 03 04", mem[8], mem[9], mem[10], mem[11]);
        end
        n_tests++;
        if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL abort_cpu_rdata got %h exp 0", cpu_rdata); end
    endtask

    task automatic test_addr_change();
        logic [31:0] w, rd;
        logic [ADDR_W-1:0] a;
        int lat, stray;
        bit al, wb;
        for (int n = 0; n < 3; n++) begin
            a = ADDR_W'($urandom);
            w = $urandom;
            run_word(1'b0, 1'b1, a, w, 1'b1, rd, lat, stray, al, wb);
            ref_write(a, w);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            n_tests++;
            if (mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL latch_mem[%0d] got %h exp %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] w, rd, exp_w;
        logic [ADDR_W-1:0] a;
        logic port, we;
        int lat, stray;
        bit al, wb;
        for (int n = 0; n < 16; n++) begin
            port = 1'($urandom);
            we   = 1'($urandom);
            a    = ADDR_W'($urandom);
            w    = $urandom;
            exp_w = ref_read(a);
            run_word(port, we, a, w, 1'b0, rd, lat, stray, al, wb);
            if (we) begin
                ref_write(a, w);
            end else begin
                n_tests++;
                if (rd !== exp_w) begin
                    n_fail++;
                    $display("FAIL rand_read port %0d addr %h got %h exp %h", port, a, rd, exp_w);
                end
            end
            n_tests++;
            if (lat != 6 || stray != 0 || al || wb) begin
                n_fail++;
                $display("FAIL rand_handshake txn %0d got lat=%0d stray=%0d long=%0d webad=%0d exp 6 0 0 0",
                         n, lat, stray, al, wb);
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            n_tests++;
            if (mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL rand_mem[%0d] got %h exp %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_cpu_write();
        test_ldr_read();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_addr_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
